// File: rtl/vend_pkg.sv
// Shared vending definitions: FSM states, payout channel encoding, priority pick.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FIRE  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_GAP   = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CH_SODA = 2'd0,
        CH_2    = 2'd1,
        CH_1    = 2'd2
    } chan_t;

    localparam int unsigned NUM_CH = 3;

    // Fixed service priority: soda first, then the 2-coin hopper, then the 1-coin hopper.
    function automatic chan_t prio_pick(input logic has_soda, input logic has_2, input logic has_1);
        chan_t ch;
        ch = CH_1;
        if (has_soda) begin
            ch = CH_SODA;
        end else if (has_2) begin
            ch = CH_2;
        end else if (has_1) begin
            ch = CH_1;
        end
        return ch;
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request/actuator bundle between the vending FSM, the dispenser and the actuator drivers.
interface change_dispenser_if #(
    parameter int unsigned CNT_W = 4
);
    logic             req_soda;
    logic             req_1;
    logic             req_2;
    logic             req_2x2;
    logic             done_soda;
    logic             done_1;
    logic             done_2;
    logic             fire_soda;
    logic             fire_1;
    logic             fire_2;
    logic             busy;
    logic             fault;
    logic             overflow;
    logic [CNT_W-1:0] pend_soda;
    logic [CNT_W-1:0] pend_1;
    logic [CNT_W-1:0] pend_2;

    // Environment side: issues payout requests and actuator completions.
    modport master (
        output req_soda, req_1, req_2, req_2x2,
        output done_soda, done_1, done_2,
        input  fire_soda, fire_1, fire_2,
        input  busy, fault, overflow,
        input  pend_soda, pend_1, pend_2
    );

    // Dispenser side.
    modport slave (
        input  req_soda, req_1, req_2, req_2x2,
        input  done_soda, done_1, done_2,
        output fire_soda, fire_1, fire_2,
        output busy, fault, overflow,
        output pend_soda, pend_1, pend_2
    );
endinterface

// File: rtl/change_dispenser_pend_counter.sv
// Saturating pending-request counter with sticky overflow flag.
module pend_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);
    localparam int unsigned EXT_W = CNT_W + 2;
    localparam logic [EXT_W-1:0] MAX = {2'b00, {CNT_W{1'b1}}};

    logic [EXT_W-1:0] sum;

    // Net increment and decrement before clamping.
    always_comb begin
        sum = EXT_W'(cnt) + EXT_W'(inc);
        if (dec && (sum != '0)) begin
            sum = sum - EXT_W'(1);
        end
    end

    // Clamp at full scale; remember any lost request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (sum > MAX) begin
            cnt <= '1;
            ovf <= 1'b1;
        end else begin
            cnt <= sum[CNT_W-1:0];
        end
    end
endmodule

// File: rtl/change_dispenser.sv
// Payout back-end: queues payout pulses per channel and drives one actuator at a time.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned GAP     = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    change_dispenser_if.slave bus
);
    // The IDLE arbitration cycle is the last idle cycle of the gap, so GAP holds GAP-1 cycles.
    localparam int unsigned GAP_CYC = (GAP > 1) ? (GAP - 1) : 1;
    localparam int unsigned GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int unsigned TMO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t             state_q, state_d;
    chan_t              sel_q, sel_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [NUM_CH-1:0]  fire_q, fire_d;
    logic               fault_q;
    logic               dec_soda, dec_1, dec_2;
    logic               done_sel;
    logic               any_pend;
    chan_t              pick;
    logic [CNT_W-1:0]   cnt_soda, cnt_1, cnt_2;
    logic               ovf_soda, ovf_1, ovf_2;

    pend_counter #(.CNT_W(CNT_W)) u_pend_soda (
        .clk(clk), .rst(rst), .inc({1'b0, bus.req_soda}), .dec(dec_soda),
        .cnt(cnt_soda), .ovf(ovf_soda)
    );

    pend_counter #(.CNT_W(CNT_W)) u_pend_1 (
        .clk(clk), .rst(rst), .inc({1'b0, bus.req_1}), .dec(dec_1),
        .cnt(cnt_1), .ovf(ovf_1)
    );

    // req_2x2 weighs two, req_2 one: the pair forms the increment directly.
    pend_counter #(.CNT_W(CNT_W)) u_pend_2 (
        .clk(clk), .rst(rst), .inc({bus.req_2x2, bus.req_2}), .dec(dec_2),
        .cnt(cnt_2), .ovf(ovf_2)
    );

    // Next state, channel select, timers and actuation decode.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        tmo_d    = tmo_q;
        gap_d    = gap_q;
        dec_soda = 1'b0;
        dec_1    = 1'b0;
        dec_2    = 1'b0;
        fire_d   = '0;
        any_pend = (cnt_soda != '0) || (cnt_2 != '0) || (cnt_1 != '0);
        pick     = prio_pick(cnt_soda != '0, cnt_2 != '0, cnt_1 != '0);

        unique case (sel_q)
            CH_SODA: done_sel = bus.done_soda;
            CH_2:    done_sel = bus.done_2;
            CH_1:    done_sel = bus.done_1;
            default: done_sel = 1'b0;
        endcase

        unique case (state_q)
            ST_IDLE: begin
                if (any_pend) begin
                    sel_d    = pick;
                    state_d  = ST_FIRE;
                    dec_soda = (pick == CH_SODA);
                    dec_2    = (pick == CH_2);
                    dec_1    = (pick == CH_1);
                end
            end
            ST_FIRE: begin
                tmo_d   = '0;
                gap_d   = '0;
                state_d = done_sel ? ST_GAP : ST_WAIT;
            end
            ST_WAIT: begin
                if (done_sel) begin
                    gap_d   = '0;
                    state_d = ST_GAP;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d = ST_FAULT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(GAP_CYC - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase

        if (state_d == ST_FIRE) begin
            fire_d[0] = (sel_d == CH_SODA);
            fire_d[1] = (sel_d == CH_2);
            fire_d[2] = (sel_d == CH_1);
        end
    end

    // State register plus registered fire/fault outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= CH_SODA;
            tmo_q   <= '0;
            gap_q   <= '0;
            fire_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            tmo_q   <= tmo_d;
            gap_q   <= gap_d;
            fire_q  <= fire_d;
            fault_q <= (state_d == ST_FAULT);
        end
    end

    assign bus.fire_soda = fire_q[0];
    assign bus.fire_2    = fire_q[1];
    assign bus.fire_1    = fire_q[2];
    assign bus.fault     = fault_q;
    assign bus.overflow  = ovf_soda | ovf_1 | ovf_2;
    assign bus.busy      = (state_q != ST_IDLE) || (cnt_soda != '0) || (cnt_1 != '0) || (cnt_2 != '0);
    assign bus.pend_soda = cnt_soda;
    assign bus.pend_1    = cnt_1;
    assign bus.pend_2    = cnt_2;
endmodule
